// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam logic PRIO0 = 1'b0;
    localparam logic PRIO1 = 1'b1;

    localparam int          REG_IDX_W = 5;
    localparam logic [4:0]  X0        = 5'd0;

endpackage

// File: rtl/regfile_wb_arbiter_starve_counter.sv
// Saturating stall counter for the low-priority writeback requester.
module starve_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_max,
    output logic o_hit
);

    localparam logic [3:0] MAX = 4'(MAX_WAIT);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_inc && (r_cnt != MAX)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // o_hit: this edge takes the count up to MAX
    assign o_at_max = (r_cnt == MAX);
    assign o_hit    = i_inc && !i_clr && (r_cnt == MAX - 4'd1);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between ALU and LSU writeback,
// with a registered write stage and an anti-starvation override.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_rd,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_rd,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              starve_flag
);

    logic              r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0] w_data;
    logic              w_inc;
    logic              w_clr;
    logic              w_withdraw;
    logic              w_at_max;
    logic              w_hit;

    // PRIO1 lets req1 win; otherwise req1 only gets idle slots
    assign w_gnt1 = req1_valid && ((r_state == PRIO1) || !req0_valid);
    assign w_gnt0 = req0_valid && !w_gnt1;

    assign req0_ready = w_gnt0 && !rst;
    assign req1_ready = w_gnt1 && !rst;

    assign w_xfer = req0_ready || req1_ready;
    assign w_rd   = req1_ready ? req1_rd   : req0_rd;
    assign w_data = req1_ready ? req1_data : req0_data;

    assign w_withdraw = (r_state == PRIO1) && !req1_valid;
    assign w_inc      = req1_valid && !req1_ready;
    assign w_clr      = req1_ready || w_withdraw;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_inc    (w_inc),
        .i_clr    (w_clr),
        .o_at_max (w_at_max),
        .o_hit    (w_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PRIO0;
        end else if (r_state == PRIO0) begin
            if (w_hit || (w_at_max && req1_valid)) begin
                r_state <= PRIO1;
            end
        end else if (req1_ready || w_withdraw) begin
            r_state <= PRIO0;
        end
    end

    // rd==x0 is accepted but never enabled at the register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_xfer) begin
            r_we    <= (w_rd != ADDR_W'(X0));
            r_waddr <= w_rd;
            r_wdata <= w_data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign rf_we       = r_we;
    assign rf_waddr    = r_waddr;
    assign rf_wdata    = r_wdata;
    assign starve_flag = (r_state == PRIO1);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        starve_flag;

    int n_chk;
    int n_fail;

    regfile_wb_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_rd     (req0_rd),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_rd     (req1_rd),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .starve_flag (starve_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one step: 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_rd    = 5'd9;
        req0_data  = 32'h1;
        req1_valid = 1'b1;
        req1_rd    = 5'd8;
        req1_data  = 32'h2;

        // reset state, readies gated by rst
        cyc();
        chk("rst_we", 32'(rf_we), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        chk("rst_rdy0", 32'(req0_ready), 32'd0);
        chk("rst_rdy1", 32'(req1_ready), 32'd0);
        chk("rst_starve", 32'(starve_flag), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;

        // single writer
        cyc();
        req0_valid = 1'b1;
        req0_rd    = 5'd5;
        req0_data  = 32'hDEADBEEF;
        #1;
        chk("single_rdy0", 32'(req0_ready), 32'd1);
        chk("single_rdy1", 32'(req1_ready), 32'd0);
        cyc();
        req0_valid = 1'b0;
        chk("single_we", 32'(rf_we), 32'd1);
        chk("single_waddr", 32'(rf_waddr), 32'd5);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        cyc();
        chk("single_we_off", 32'(rf_we), 32'd0);
        chk("idle_waddr_hold", 32'(rf_waddr), 32'd5);
        chk("idle_wdata_hold", rf_wdata, 32'hDEADBEEF);

        // conflict on the same rd
        req0_valid = 1'b1;
        req0_rd    = 5'd3;
        req0_data  = 32'h11;
        req1_valid = 1'b1;
        req1_rd    = 5'd3;
        req1_data  = 32'h22;
        #1;
        chk("conf_rdy0", 32'(req0_ready), 32'd1);
        chk("conf_rdy1", 32'(req1_ready), 32'd0);
        cyc();
        req0_valid = 1'b0;
        chk("conf_w1_we", 32'(rf_we), 32'd1);
        chk("conf_w1_addr", 32'(rf_waddr), 32'd3);
        chk("conf_w1_data", rf_wdata, 32'h11);
        #1;
        chk("conf_rdy1_b", 32'(req1_ready), 32'd1);
        cyc();
        req1_valid = 1'b0;
        chk("conf_w2_we", 32'(rf_we), 32'd1);
        chk("conf_w2_addr", 32'(rf_waddr), 32'd3);
        chk("conf_w2_data", rf_wdata, 32'h22);
        cyc();

        // starvation: req0 always valid, req1 stalls 4 cycles
        req0_valid = 1'b1;
        req0_rd    = 5'd1;
        req0_data  = 32'hA0;
        req1_valid = 1'b1;
        req1_rd    = 5'd2;
        req1_data  = 32'hB0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("stv_rdy1_c%0d", k), 32'(req1_ready), 32'd0);
            chk($sformatf("stv_flag_c%0d", k), 32'(starve_flag), 32'd0);
            cyc();
        end
        chk("stv_flag_c4", 32'(starve_flag), 32'd1);
        chk("stv_cnt_c4", 32'(dut.u_cnt.r_cnt), 32'd4);
        #1;
        chk("stv_rdy1_c4", 32'(req1_ready), 32'd1);
        chk("stv_rdy0_c4", 32'(req0_ready), 32'd0);
        cyc();
        req1_valid = 1'b0;
        chk("stv_flag_c5", 32'(starve_flag), 32'd0);
        chk("stv_w_addr", 32'(rf_waddr), 32'd2);
        chk("stv_w_data", rf_wdata, 32'hB0);
        chk("stv_cnt_c5", 32'(dut.u_cnt.r_cnt), 32'd0);
        #1;
        chk("stv_rdy0_c5", 32'(req0_ready), 32'd1);

        // x0 write after two stalled cycles
        cyc();
        req1_valid = 1'b1;
        req1_rd    = 5'd0;
        req1_data  = 32'hFFFFFFFF;
        cyc();
        cyc();
        chk("x0_cnt_pre", 32'(dut.u_cnt.r_cnt), 32'd2);
        req0_valid = 1'b0;
        #1;
        chk("x0_rdy1", 32'(req1_ready), 32'd1);
        cyc();
        req1_valid = 1'b0;
        chk("x0_we", 32'(rf_we), 32'd0);
        chk("x0_waddr", 32'(rf_waddr), 32'd0);
        chk("x0_wdata", rf_wdata, 32'hFFFFFFFF);
        chk("x0_cnt", 32'(dut.u_cnt.r_cnt), 32'd0);
        cyc();

        // withdrawal while in PRIO1
        req0_valid = 1'b1;
        req0_rd    = 5'd4;
        req0_data  = 32'hC0;
        req1_valid = 1'b1;
        req1_rd    = 5'd6;
        req1_data  = 32'hD0;
        repeat (4) cyc();
        chk("wd_flag", 32'(starve_flag), 32'd1);
        req1_valid = 1'b0;
        #1;
        chk("wd_rdy0", 32'(req0_ready), 32'd1);
        chk("wd_rdy1", 32'(req1_ready), 32'd0);
        cyc();
        chk("wd_flag_off", 32'(starve_flag), 32'd0);
        chk("wd_cnt", 32'(dut.u_cnt.r_cnt), 32'd0);
        req1_valid = 1'b1;
        #1;
        chk("wd_rdy0_b", 32'(req0_ready), 32'd1);
        repeat (3) cyc();
        chk("wd_flag_3", 32'(starve_flag), 32'd0);
        cyc();
        chk("wd_flag_4", 32'(starve_flag), 32'd1);

        // reset mid-cycle with a write pending
        req1_valid = 1'b0;
        req0_rd    = 5'd7;
        req0_data  = 32'h77;
        cyc();
        chk("mid_pend_we", 32'(rf_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_we", 32'(rf_we), 32'd0);
        chk("mid_waddr", 32'(rf_waddr), 32'd0);
        chk("mid_wdata", rf_wdata, 32'd0);
        chk("mid_rdy0", 32'(req0_ready), 32'd0);
        chk("mid_flag", 32'(starve_flag), 32'd0);
        cyc();
        rst = 1'b0;
        req1_valid = 1'b1;
        #1;
        chk("post_rdy0", 32'(req0_ready), 32'd1);
        chk("post_rdy1", 32'(req1_ready), 32'd0);
        chk("post_cnt", 32'(dut.u_cnt.r_cnt), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
